word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
Parametrised successor to the 64-to-8 UART serializer FSM. Accepts one WORD_W-bit word over a valid/ready handshake and splits it into WORD_W/SYM_W symbols. Issues each symbol to the UART transmitter with a one-cycle start pulse, then waits for that transmitter's done pulse before sending the next. Sits between the pipelined DES output stage and uart_tx; adds selectable symbol order, abort, and frame-complete signalling.

Parameters:
WORD_W, 64, input word width; must be an integer multiple of SYM_W.
SYM_W, 8, symbol width presented to the UART.
MSB_FIRST, 1, 1 = most-significant symbol sent first; 0 = least-significant symbol sent first.

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a word; high only in IDLE.
in_data  input  WORD_W  word to serialize.
abort  input  1  synchronous cancel of the current frame.
sym_done  input  1  one-cycle pulse from the UART: current symbol has been sent.
sym_start  output  1  registered one-cycle pulse: sym_data is valid, start transmission.
sym_data  output  SYM_W  registered symbol to transmit.
frame_done  output  1  one-cycle pulse after the last symbol completes.
idle  output  1  high in IDLE.

Behaviour:
- Localparam NUM_SYM = WORD_W/SYM_W (plus 1 when CHECKSUM_EN is defined). Symbol counter width is $clog2(NUM_SYM+1).
- Reset values: state IDLE, in_ready 1, idle 1, sym_start 0, sym_data 0, frame_done 0, counter 0, shift register 0.
- States:
  - IDLE
  - WAIT: a symbol is in flight.
  - DONE
- IDLE:
  - On in_valid & in_ready, capture in_data into the shift register at edge N, go to WAIT, and clear the counter.
  - In cycle N+1: sym_start = 1 and sym_data = the first symbol (in_data[WORD_W-1 -: SYM_W] if MSB_FIRST, else in_data[SYM_W-1:0]).
- WAIT:
  - sym_start is high only for the first cycle of each symbol.
  - sym_done is ignored while sym_start is high.
  - On sym_done with counter < NUM_SYM-1: shift by SYM_W toward the send end, increment the counter, and in the next cycle assert sym_start with the new sym_data (one-cycle turnaround).
  - On sym_done with counter == NUM_SYM-1: go to DONE.
  - sym_data holds its value between symbols.
- DONE: frame_done = 1 for exactly one cycle, then IDLE. in_ready returns high the cycle after DONE.
- Back-to-back words: a word presented while busy is stalled (in_ready = 0) and is not lost; it is accepted on the first IDLE cycle.
- sym_done in IDLE or DONE is ignored.
- abort (any state other than IDLE): next state IDLE, counter 0, sym_start 0, no frame_done. An abort in IDLE is a no-op. abort has priority over a simultaneous sym_done.
- Asynchronous reset mid-frame: immediate return to reset values; the partial frame is discarded.
- Unreachable state encodings go to IDLE.

Optional Feature:
CHECKSUM_EN:
- Defined: after the last data symbol, one extra symbol is sent, equal to the XOR of all data symbols (accumulated at capture time). NUM_SYM grows by 1, and frame_done follows the checksum symbol's sym_done.
- Undefined: only WORD_W/SYM_W data symbols are sent; no checksum logic is built.

Decomposition:
- Package fsm_pkgs: typedef enum logic [1:0] {SER_IDLE, SER_WAIT, SER_DONE} word_serializer_state_encoding, plus a function sym_count(WORD_W, SYM_W).
- Sub-module sym_shift_reg: loadable shifter with MSB_FIRST direction and the current-symbol output. It keeps the FSM free of datapath code.

Test Plan:
- WORD_W=64, SYM_W=8, MSB_FIRST=1, in_data=64'h0123456789ABCDEF, UART model returns sym_done 10 cycles after each sym_start -> sym_data sequence 01,23,45,67,89,AB,CD,EF; 8 sym_start pulses; a single frame_done; in_ready low throughout.
- Same word with MSB_FIRST=0 -> sequence EF,CD,AB,89,67,45,23,01.
- CHECKSUM_EN defined, in_data=64'h1122334455667788 -> 9 symbols, the last being 8'h88; frame_done only after the 9th sym_done.
- Two words with in_valid held continuously -> the second word is accepted only after DONE; 16 symbols total, in order; exactly two frame_done pulses.
- abort asserted with sym_done on the 4th symbol -> next cycle IDLE, no further sym_start, no frame_done; a following word serializes correctly from symbol 0.
- Reset pulled low during the 3rd symbol -> all outputs take reset values asynchronously; stray sym_done pulses in IDLE produce no sym_start.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// fsm_pkgs: state encoding and symbol-count helper shared by word_serializer.
// CHECKSUM_EN adds one trailing XOR checksum symbol to every frame.
package fsm_pkgs;

    typedef enum logic [1:0] {SER_IDLE, SER_WAIT, SER_DONE} word_serializer_state_encoding;

    function automatic int sym_count(input int word_w, input int sym_w);
`ifdef CHECKSUM_EN
        return word_w / sym_w + 1;
`else
        return word_w / sym_w;
`endif
    endfunction

endpackage

// File: rtl/word_serializer_sym_shift_reg.sv
// sym_shift_reg: loadable symbol shifter; nxt_sym is the symbol that becomes current
// after this cycle's load or shift, so the FSM can register it directly.
module sym_shift_reg #(
    parameter int TOT_W     = 64,
    parameter int SYM_W     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [TOT_W-1:0] load_data,
    output logic [SYM_W-1:0] nxt_sym
);

    logic [TOT_W-1:0] shreg_q, shreg_d, shifted;

    function automatic logic [SYM_W-1:0] head(input logic [TOT_W-1:0] v);
        return (MSB_FIRST != 0) ? v[TOT_W-1 -: SYM_W] : v[SYM_W-1:0];
    endfunction

    assign shifted = (MSB_FIRST != 0) ? shreg_q << SYM_W : shreg_q >> SYM_W;
    assign shreg_d = load ? load_data : shift ? shifted : shreg_q;
    assign nxt_sym = head(load ? load_data : shifted);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) shreg_q <= '0;
        else        shreg_q <= shreg_d;
    end

endmodule

// File: rtl/word_serializer.sv
// word_serializer: splits a WORD_W word into SYM_W symbols paced by the UART's done pulse.
// Build with CHECKSUM_EN to append an XOR checksum symbol after the data symbols.
module word_serializer
    import fsm_pkgs::*;
#(
    parameter int WORD_W    = 64,
    parameter int SYM_W     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              abort,
    input  logic              sym_done,
    output logic              sym_start,
    output logic [SYM_W-1:0]  sym_data,
    output logic              frame_done,
    output logic              idle
);

    localparam int NUM_SYM = sym_count(WORD_W, SYM_W);
    localparam int TOT_W   = NUM_SYM * SYM_W;
    localparam int CW      = $clog2(NUM_SYM + 1);

    word_serializer_state_encoding state_q;
    logic [CW-1:0]    cnt_q;
    logic             sym_start_q, frame_done_q;
    logic [SYM_W-1:0] sym_data_q, nxt_sym;
    logic [TOT_W-1:0] load_data;
    logic             load, adv, last, shift;

`ifdef CHECKSUM_EN
    localparam int NDATA = WORD_W / SYM_W;
    logic [SYM_W-1:0] csum;
    always_comb begin
        csum = '0;
        for (int i = 0; i < NDATA; i++) csum ^= in_data[i*SYM_W +: SYM_W];
    end
    // checksum sits at the far end so it leaves after the last data symbol
    assign load_data = (MSB_FIRST != 0) ? {in_data, csum} : {csum, in_data};
`else
    assign load_data = in_data;
`endif

    assign load  = (state_q == SER_IDLE) && in_valid;
    assign adv   = (state_q == SER_WAIT) && !sym_start_q && sym_done && !abort;
    assign last  = cnt_q == CW'(NUM_SYM - 1);
    assign shift = adv && !last;

    sym_shift_reg #(.TOT_W(TOT_W), .SYM_W(SYM_W), .MSB_FIRST(MSB_FIRST)) u_shift (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .load_data (load_data),
        .nxt_sym   (nxt_sym)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= SER_IDLE;
            cnt_q        <= '0;
            sym_start_q  <= 1'b0;
            sym_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            sym_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                SER_IDLE: if (load) begin
                    state_q     <= SER_WAIT;
                    cnt_q       <= '0;
                    sym_start_q <= 1'b1;
                    sym_data_q  <= nxt_sym;
                end
                SER_WAIT: if (abort) begin
                    state_q <= SER_IDLE;
                    cnt_q   <= '0;
                end else if (adv && last) begin
                    state_q      <= SER_DONE;
                    frame_done_q <= 1'b1;
                end else if (adv) begin
                    cnt_q       <= cnt_q + 1'b1;
                    sym_start_q <= 1'b1;
                    sym_data_q  <= nxt_sym;
                end
                default: begin
                    state_q <= SER_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign in_ready   = state_q == SER_IDLE;
    assign idle       = state_q == SER_IDLE;
    assign sym_start  = sym_start_q;
    assign sym_data   = sym_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: MSB-first and LSB-first instances driven in lockstep, checked
// against a word-to-symbol-list reference model.
module tb_word_serializer;

    localparam int WW = 64;
    localparam int SW = 8;
    localparam int ND = WW / SW;
`ifdef CHECKSUM_EN
    localparam int NS = ND + 1;
`else
    localparam int NS = ND;
`endif

    logic          clock = 1'b0, reset = 1'b0, in_valid = 1'b0, abort = 1'b0, sym_done = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          rdy_m, rdy_l, st_m, st_l, fd_m, fd_l, id_m, id_l;
    logic [SW-1:0] sd_m, sd_l;
    int            total = 0, bad = 0;

    always #5 clock = ~clock;

    word_serializer #(.WORD_W(WW), .SYM_W(SW), .MSB_FIRST(1)) dut_m (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
        .abort(abort), .sym_done(sym_done), .sym_start(st_m), .sym_data(sd_m),
        .frame_done(fd_m), .idle(id_m)
    );

    word_serializer #(.WORD_W(WW), .SYM_W(SW), .MSB_FIRST(0)) dut_l (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
        .abort(abort), .sym_done(sym_done), .sym_start(st_l), .sym_data(sd_l),
        .frame_done(fd_l), .idle(id_l)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // symbol i of word w in transmission order; index ND is the XOR checksum
    function automatic logic [SW-1:0] model_sym(input logic [WW-1:0] w, input int i, input bit msb);
        logic [SW-1:0] x = '0;
        if (i < ND) return SW'(w >> (SW * (msb ? ND - 1 - i : i)));
        for (int k = 0; k < ND; k++) x ^= SW'(w >> (SW * k));
        return x;
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, {st_m, st_l, fd_m, fd_l, sd_m, sd_l, rdy_m, rdy_l, id_m, id_l}, 20'h0000f);
    endtask

    // mode 0: full frame, 1: abort with sym_done on symbol 'at', 2: reset during symbol 'at'
    task automatic run_frame(input logic [WW-1:0] w, input int mode, input int at, input bit hold,
                             input logic [WW-1:0] w2, input bit fixed, input bit imm);
        int cyc = 0;
        bit acc = 0;
        int d, stray;
        in_data  = w;
        in_valid = 1'b1;
        while (!acc && cyc < 50) begin
            acc = rdy_m && rdy_l;
            step;
            cyc++;
        end
        chk("accept", {63'b0, acc}, 1);
        if (!acc) return;
        if (imm) chk("accept_first_idle", cyc, 1);
        in_valid = hold;
        if (hold) in_data = w2;
        for (int i = 0; i < NS; i++) begin
            chk("start", {st_m, st_l}, 2'b11);
            chk("sym_msb", sd_m, model_sym(w, i, 1));
            chk("sym_lsb", sd_l, model_sym(w, i, 0));
            chk("busy", {rdy_m, rdy_l, id_m, id_l, fd_m, fd_l}, 0);
            d = fixed ? 10 : int'($urandom_range(1, 12));
            sym_done = 1'($urandom_range(0, 1));
            stray = 0;
            step;
            for (int j = 1; j < d; j++) begin
                if (mode == 2 && i == at && j == 3) begin
                    reset = 1'b0;
                    #1;
                    chk_reset_vals("async_reset");
                    sym_done = 1'b0;
                    step;
                    chk_reset_vals("held_reset");
                    reset = 1'b1;
                    for (int k = 0; k < 5; k++) begin
                        sym_done = 1'b1;
                        step;
                        sym_done = 1'b0;
                        if (st_m || st_l || !id_m || !id_l) stray++;
                        step;
                    end
                    chk("idle_stray_done", stray, 0);
                    return;
                end
                if (st_m || st_l || sd_m !== model_sym(w, i, 1) || sd_l !== model_sym(w, i, 0)) stray++;
                sym_done = 1'b0;
                step;
            end
            if (st_m || st_l || fd_m || fd_l) stray++;
            sym_done = 1'b1;
            abort    = (mode == 1 && i == at);
            step;
            sym_done = 1'b0;
            abort    = 1'b0;
            chk("gap_hold", stray, 0);
            if (mode == 1 && i == at) begin
                chk("abort_idle", {id_m, id_l, rdy_m, rdy_l, st_m, st_l, fd_m, fd_l}, 8'hf0);
                stray = 0;
                for (int k = 0; k < 15; k++) begin
                    if (st_m || st_l || fd_m || fd_l) stray++;
                    step;
                end
                chk("abort_quiet", stray, 0);
                return;
            end
        end
        chk("frame_done", {fd_m, fd_l, st_m, st_l, rdy_m, rdy_l}, 6'b110000);
        step;
        chk("frame_done_once", {fd_m, fd_l}, 0);
        chk("ready_back", {rdy_m, rdy_l, id_m, id_l}, 4'hf);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        step;
        step;
        chk_reset_vals("reset_state");
        reset = 1'b1;
        step;
        chk_reset_vals("post_reset_state");
        sym_done = 1'b1;
        step;
        sym_done = 1'b0;
        chk("idle_done_ignored", {st_m, st_l, id_m, id_l}, 4'b0011);
        abort = 1'b1;
        step;
        abort = 1'b0;
        chk("idle_abort_noop", {st_m, st_l, id_m, id_l, rdy_m, rdy_l}, 6'b001111);
        run_frame(64'h0123456789ABCDEF, 0, 0, 0, '0, 1, 0);
        run_frame(64'h1122334455667788, 0, 0, 0, '0, 1, 0);
        run_frame(64'hA5A5_0F0F_3C3C_FF00, 0, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 0, 0);
        run_frame(64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, '0, 0, 1);
        run_frame({$urandom, $urandom}, 1, 3, 0, '0, 1, 0);
        run_frame(64'h0123456789ABCDEF, 0, 0, 0, '0, 0, 0);
        run_frame({$urandom, $urandom}, 2, 2, 0, '0, 1, 0);
        run_frame({$urandom, $urandom}, 0, 0, 0, '0, 0, 0);
        for (int n = 0; n < 4; n++) run_frame({$urandom, $urandom}, 0, 0, 0, '0, 0, 0);
        run_frame({$urandom, $urandom}, 1, NS - 1, 0, '0, 0, 0);
        run_frame({$urandom, $urandom}, 0, 0, 0, '0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
